perf_counter_bank: RTL
======================

# perf_counter_bank

Synthesizable event-counter bank that replaces the bench-only hit/request/instruction tallies with hardware counters inside the processor hierarchy. It has NUM_CH independent event counters plus one free-running cycle counter. Counting freezes when the processor halts. Any counter can be read back through a registered single-cycle read port. The block sits beside the pipeline: event strobes come from the cache and writeback stages, and readout goes to the debug/monitor path.

## Interface
- NUM_CH, default 4: number of event channels (1..15).
- CNT_W, default 32: counter width in bits (8..64).
- SATURATE, default 0: overflow behaviour. 0 = wrap to 0; 1 = hold at all-ones.
- SEL_W, default 3: read-select width. Must satisfy 2^SEL_W >= NUM_CH+1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- count_en, in, 1: global count enable.
- evt, in, NUM_CH: per-channel event strobes; each asserted bit counts once per cycle.
- halt, in, 1: processor halted, asserted in writeback.
- clear, in, 1: zero all counters and overflow flags; leave FROZEN.
- rd_req, in, 1: read request.
- rd_sel, in, SEL_W: select. 0..NUM_CH-1 = event channel; NUM_CH = cycle counter.
- rd_valid, out, 1: read data valid.
- rd_data, out, CNT_W: read data.
- rd_err, out, 1: rd_sel out of range.
- ovf, out, NUM_CH+1: sticky overflow flags. Bit NUM_CH is the cycle counter.
- frozen, out, 1: block is in FROZEN state.

## Operation
- Two states: COUNT and FROZEN. Reset state is COUNT.
- COUNT → FROZEN: on the first cycle with halt=1.
- FROZEN → COUNT: only on clear=1. halt is ignored while in FROZEN.
- In COUNT with count_en=1:
  - The cycle counter increments every cycle.
  - Channel i increments when evt[i]=1.
- count_en=0: all counters hold. The state machine still responds to halt and clear.
- Halt cycle: the halt cycle's own events and cycle tick are counted; freeze takes effect from the next cycle. This matches the halting instruction being counted as retired.
- Wrap mode (SATURATE=0): an increment from all-ones gives 0 and sets ovf[i].
- Saturate mode (SATURATE=1): an increment at all-ones holds the value and sets ovf[i].
- ovf bits are sticky until clear or rst.
- clear has priority over events and halt in the same cycle: all counters and ovf become 0, state becomes COUNT, and same-cycle events are dropped.
- Read port:
  - rd_req samples rd_sel.
  - Next cycle: rd_valid=1 and rd_data = the counter value as it stood at the end of the request cycle, before that cycle's increment.
  - rd_sel > NUM_CH: rd_data=0 and rd_err=1 alongside rd_valid.
  - Back-to-back requests are allowed, one per cycle, fully pipelined.
  - Reads do not disturb counting or state.

## Timing
- Counter update and read latency are both 1 cycle; all outputs are registered.
- Reset values: every counter 0, ovf=0, rd_valid=0, rd_data=0, rd_err=0, frozen=0, state COUNT.
- rst mid-operation: all of the above on the next edge. A read issued in the reset cycle is discarded (rd_valid=0 next cycle).
- rd_valid is a one-cycle pulse per request. With no rd_req, rd_valid=0 and rd_data/rd_err hold their last values.
- frozen=1 from the cycle after halt is sampled until the cycle after clear is sampled.
- Cycle-counter value at freeze equals the number of count_en cycles after reset, including the halt cycle.

## Test plan
- Basic count:
  - Stimulus: reset, count_en=1, evt=4'b0101 for 10 cycles, then halt.
  - Required: reading sel 0, 1, 2, 3, 4 returns 11, 0, 11, 0, 11 (halt cycle included). frozen=1, and counters stay fixed for 20 further cycles of events.
- Wrap and saturate (CNT_W=8):
  - Stimulus: evt[0] held for 257 cycles.
  - Required: SATURATE=0 reads 1 with ovf[0]=1. SATURATE=1 reads 255 with ovf[0]=1.
- Clear priority:
  - Stimulus: clear asserted in the same cycle as evt=4'b1111 and halt, while in FROZEN.
  - Required: all reads 0, ovf=0, frozen=0 next cycle. Counting resumes the cycle after that.
- Read pipeline:
  - Stimulus: rd_req on 3 consecutive cycles with sel 0, 4, 7 (NUM_CH=4) while evt[0] toggles.
  - Required: rd_valid high for 3 cycles, each value equal to the pre-increment value. Sel 7 gives rd_err=1 and rd_data=0.
- Enable gating:
  - Stimulus: count_en=0 for 5 cycles in the middle of a 10-cycle evt[1] burst.
  - Required: channel 1 and the cycle counter each advance by exactly 5.
- Reset mid-run:
  - Stimulus: rst asserted in the same cycle as rd_req after 50 cycles of counting.
  - Required: rd_valid=0 next cycle, all counters 0, frozen=0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Event-counter bank: NUM_CH event counters plus a free-running cycle counter, frozen on halt.
// Latency: counter update 1 cycle; read data registered, valid 1 cycle after rd_req.
// Backpressure: none; one read per cycle is accepted and reads never stall counting.
module perf_counter_bank #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0,
    parameter int SEL_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count_en,
    input  logic [NUM_CH-1:0] evt,
    input  logic              halt,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_err,
    output logic [NUM_CH:0]   ovf,
    output logic              frozen
);

    // Counter NUM_CH is the cycle counter; it ticks whenever counting is live.
    localparam int NCNT = NUM_CH + 1;

    typedef enum logic {
        COUNT  = 1'b0,
        FROZEN = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cntQ [NCNT];
    logic [NCNT-1:0]  ovfQ;
    logic [NCNT-1:0]  tick;
    logic             countNow;
    logic [CNT_W-1:0] rdMux;
    logic             selOk;

    assign tick     = {1'b1, evt};
    assign countNow = (state == COUNT) && count_en;
    assign ovf      = ovfQ;
    assign frozen   = (state == FROZEN);

    // Counters and sticky overflow flags; clear beats any same-cycle event.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NCNT; i++) begin
                cntQ[i] <= '0;
            end
            ovfQ <= '0;
        end else if (countNow) begin
            for (int i = 0; i < NCNT; i++) begin
                if (tick[i]) begin
                    if (cntQ[i] == {CNT_W{1'b1}}) begin
                        ovfQ[i] <= 1'b1;
                        // Saturating mode simply leaves the all-ones value in place.
                        if (SATURATE == 0) begin
                            cntQ[i] <= '0;
                        end
                    end else begin
                        cntQ[i] <= cntQ[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // COUNT/FROZEN control: halt freezes from the next cycle, only clear unfreezes.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= COUNT;
        end else if ((state == COUNT) && halt) begin
            state <= FROZEN;
        end
    end

    // Select the requested counter from its pre-increment register value.
    always_comb begin
        rdMux = '0;
        selOk = 1'b0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rdMux = cntQ[i];
                selOk = 1'b1;
            end
        end
    end

    // Registered read port: data/err hold between requests, valid pulses once per request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rdMux;
                rd_err  <= !selOk;
            end
        end
    end

endmodule
